// File: rtl/cpu_sequencer_if.sv
// Control bundle between the CPU sequencer and the datapath it steers.
// The sequencer drives the phase and strobes; the datapath supplies opcode and zero flag.
interface cpu_sequencer_if #(
  parameter int unsigned OPC_WIDTH = 3
);
  logic [OPC_WIDTH-1:0] opcode;
  logic                 zero;
  logic [2:0]           phase;
  logic                 sel;
  logic                 rd;
  logic                 wr;
  logic                 ld_ir;
  logic                 ld_ac;
  logic                 inc_pc;
  logic                 ld_pc;
  logic                 data_e;
  logic                 halt;

  modport master (
    input  opcode, zero,
    output phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt
  );

  modport slave (
    output opcode, zero,
    input  phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Central control FSM of the RISC CPU: an 8-phase instruction cycle with a sticky halt,
// decoding memory, IR, accumulator and program-counter strobes from phase and opcode.
module cpu_sequencer #(
  parameter int unsigned OPC_WIDTH = 3
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);

  localparam logic [OPC_WIDTH-1:0] OP_HLT = OPC_WIDTH'(0);
  localparam logic [OPC_WIDTH-1:0] OP_SKZ = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OP_ADD = OPC_WIDTH'(2);
  localparam logic [OPC_WIDTH-1:0] OP_AND = OPC_WIDTH'(3);
  localparam logic [OPC_WIDTH-1:0] OP_XOR = OPC_WIDTH'(4);
  localparam logic [OPC_WIDTH-1:0] OP_LDA = OPC_WIDTH'(5);
  localparam logic [OPC_WIDTH-1:0] OP_STO = OPC_WIDTH'(6);
  localparam logic [OPC_WIDTH-1:0] OP_JMP = OPC_WIDTH'(7);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  phase_e state_q, state_d;
  logic   halted_q, halted_d;
  logic   alu_op;
  logic   is_sto;
  logic   is_jmp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Phase advance; an HLT seen at OP_ADDR parks the machine there until reset.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (state_q == OP_ADDR && bus.opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else begin
        state_d = phase_e'(3'(state_q + 3'd1));
      end
    end
  end

  always_comb begin
    alu_op = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
             (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    is_sto = (bus.opcode == OP_STO);
    is_jmp = (bus.opcode == OP_JMP);
  end

  // Control decode; opcode only matters from OP_ADDR onward, when the IR is stable.
  always_comb begin
    bus.phase  = 3'(state_q);
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.wr     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (halted_q) begin
      bus.halt = 1'b1;
    end else begin
      case (state_q)
        INST_ADDR: begin
          bus.sel = 1'b1;
        end
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = (bus.opcode != OP_HLT);
        end
        OP_FETCH: begin
          bus.rd = alu_op;
        end
        ALU_OP: begin
          bus.rd     = alu_op;
          bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
          bus.ld_pc  = is_jmp;
          bus.data_e = is_sto;
        end
        STORE: begin
          bus.rd     = alu_op;
          bus.ld_ac  = alu_op;
          bus.ld_pc  = is_jmp;
          bus.wr     = is_sto;
          bus.data_e = is_sto;
        end
        default: begin
          bus.sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed instructions followed by random instruction streams,
// checked cycle by cycle against a rule-based model plus an instruction-level PC model.
module tb_cpu_sequencer;

  logic clk;
  logic rst;
  logic [4:0] pc;
  logic [4:0] pc_in;

  int total = 0;
  int bad   = 0;

  int   m_phase;
  bit   m_halted;
  logic [4:0] pc_exp;
  int   cur_op;
  bit   cur_zero;
  logic [4:0] cur_operand;
  int   drv_op;
  bit   drv_zero;

  cpu_sequencer_if #(.OPC_WIDTH(3)) bus ();

  cpu_sequencer #(.OPC_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External program counter driven by the sequencer strobes.
  always @(posedge clk or negedge rst) begin
    if (!rst)             pc <= 5'd0;
    else if (bus.ld_pc)   pc <= pc_in;
    else if (bus.inc_pc)  pc <= pc + 5'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t phase=%0d op=%0d)",
               tag, got, exp, $time, m_phase, drv_op);
    end
  endtask

  // Expected {sel,rd,wr,ld_ir,ld_ac,inc_pc,ld_pc,data_e,halt} from the phase rules.
  function automatic logic [8:0] exp_ctl(input int ph, input int op, input bit z, input bit hlt);
    bit alu, sel, rd, wr, ldir, ldac, inc, ldpc, de;
    if (hlt) return 9'b0_0000_0001;
    alu  = (op >= 2) && (op <= 5);
    sel  = (ph <= 3);
    rd   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    ldir = (ph == 2) || (ph == 3);
    inc  = (ph == 4 && op != 0) || (ph == 6 && op == 1 && z);
    ldpc = (ph >= 6) && (op == 7);
    de   = (ph >= 6) && (op == 6);
    wr   = (ph == 7) && (op == 6);
    ldac = (ph == 7) && alu;
    return {sel, rd, wr, ldir, ldac, inc, ldpc, de, 1'b0};
  endfunction

  function automatic logic [4:0] next_pc(input logic [4:0] p, input int op, input bit z,
                                          input logic [4:0] opd);
    if (op == 7) return opd;
    if (op == 1 && z) return p + 5'd2;
    return p + 5'd1;
  endfunction

  task automatic check_outputs();
    logic [8:0] got;
    got = {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac, bus.inc_pc, bus.ld_pc, bus.data_e, bus.halt};
    check_eq("phase", 32'(bus.phase), 32'(m_phase));
    check_eq("ctl", 32'(got), 32'(exp_ctl(m_phase, drv_op, drv_zero, m_halted)));
    check_eq("inc_ld_excl", 32'(bus.inc_pc & bus.ld_pc), 32'd0);
  endtask

  task automatic drive_inputs();
    if (m_phase < 3) begin
      drv_op   = int'($urandom_range(0, 7));
      drv_zero = 1'($urandom_range(0, 1));
    end else begin
      drv_op   = cur_op;
      drv_zero = cur_zero;
    end
    bus.opcode = 3'(drv_op);
    bus.zero   = drv_zero;
  endtask

  // One clock: advance the model, then re-drive inputs and check away from the edge.
  task automatic tick();
    int n_phase;
    bit n_halted;
    bit wrapped;
    n_phase  = m_phase;
    n_halted = m_halted;
    wrapped  = 1'b0;
    if (!m_halted) begin
      if (m_phase == 4 && drv_op == 0) n_halted = 1'b1;
      else n_phase = (m_phase + 1) % 8;
      if (m_phase == 7) begin
        pc_exp  = next_pc(pc_exp, cur_op, cur_zero, cur_operand);
        wrapped = 1'b1;
      end
    end
    @(posedge clk);
    m_phase  = n_phase;
    m_halted = n_halted;
    #1;
    drive_inputs();
    #1;
    check_outputs();
    if (wrapped) check_eq("pc", 32'(pc), 32'(pc_exp));
  endtask

  task automatic run_instr(input int op, input bit z, input logic [4:0] opd, input int ncyc);
    cur_op      = op;
    cur_zero    = z;
    cur_operand = opd;
    pc_in       = opd;
    repeat (ncyc) tick();
  endtask

  // Asynchronous reset applied between edges, held for ncyc clocks.
  task automatic do_reset(input int ncyc);
    rst      = 1'b0;
    m_phase  = 0;
    m_halted = 1'b0;
    pc_exp   = 5'd0;
    #1;
    check_outputs();
    check_eq("pc_rst", 32'(pc), 32'd0);
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    @(negedge clk);
    rst = 1'b1;
    drive_inputs();
  endtask

  initial begin
    rst         = 1'b0;
    m_phase     = 0;
    m_halted    = 1'b0;
    pc_exp      = 5'd0;
    pc_in       = 5'd0;
    cur_op      = 2;
    cur_zero    = 1'b0;
    cur_operand = 5'd0;
    drv_op      = 0;
    drv_zero    = 1'b0;
    bus.opcode  = 3'd0;
    bus.zero    = 1'b0;

    do_reset(3);

    run_instr(2, 1'b0, 5'h11, 8);        // ADD
    run_instr(1, 1'b1, 5'h00, 8);        // SKZ taken
    run_instr(1, 1'b0, 5'h00, 8);        // SKZ not taken
    run_instr(7, 1'b0, 5'h03, 8);        // JMP 0x03
    run_instr(6, 1'b1, 5'h1a, 8);        // STO
    run_instr(5, 1'b0, 5'h07, 8);        // LDA
    run_instr(0, 1'b0, 5'h00, 25);       // HLT then 20 frozen clocks
    check_eq("halt_sticky", 32'(bus.halt), 32'd1);
    do_reset(1);
    check_eq("halt_clear", 32'(bus.halt), 32'd0);
    run_instr(6, 1'b0, 5'h04, 5);        // abort STO in phase 5
    do_reset(1);

    // Walk the PC across its wrap with plain increments.
    repeat (34) run_instr(3, 1'b0, 5'h00, 8);

    for (int i = 0; i < 80; i++) begin
      int r;
      int op;
      r  = int'($urandom_range(0, 9));
      op = int'($urandom_range(1, 7));
      if (r == 0) begin
        run_instr(0, 1'($urandom_range(0, 1)), 5'($urandom), 5 + int'($urandom_range(0, 10)));
        do_reset(int'($urandom_range(0, 2)));
      end else if (r == 1) begin
        run_instr(op, 1'($urandom_range(0, 1)), 5'($urandom), int'($urandom_range(1, 7)));
        do_reset(int'($urandom_range(0, 2)));
      end else begin
        run_instr(op, 1'($urandom_range(0, 1)), 5'($urandom), 8);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
